// File: rtl/life_pkg.sv
// Shared definitions for the Game-of-Life matrix and its display scanner.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package life_pkg;

    localparam int GRID_N = 8;
    localparam int CELLS  = GRID_N * GRID_N;

    typedef enum logic [1:0] {
        CAPTURE = 2'd0,
        SCAN    = 2'd1,
        BLANK   = 2'd2
    } scan_state_t;

    // Bit position of cell[r][c] inside a flattened grid vector.
    function automatic int unsigned flat_index(input int unsigned r, input int unsigned c);
        return r * GRID_N + c;
    endfunction

endpackage

// File: rtl/life_popcount64.sv
// Population count of a 64-bit cell vector.
// Latency: combinational.
// Backpressure: none.
// Ports: vec (cells, 1 = alive) -> count (0..64).
module life_popcount64
    import life_pkg::*;
(
    input  logic [CELLS-1:0] vec,
    output logic [6:0]       count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < CELLS; i++) begin
            count = count + 7'(vec[i]);
        end
    end

endmodule

// File: rtl/life_display_scan.sv
// Frame-buffered row-multiplexed LED scan of the 8x8 life grid, with per-frame status.
// Latency: row_sel/col_data registered one cycle behind the scan state; status one cycle after a loading capture.
// Backpressure: none; gen_tick events are coalesced into a pending flag sampled only at frame boundaries.
// Ports: clk, _rst (async active-low); grid_flat/gen_tick from the matrix; row_sel/col_data to the LED
//        matrix; frame_done pulse; live_count/extinct/still status.
// Build option: define LIFE_SCAN_BLANK_EN to insert BLANK all-off cycles between consecutive rows.
module life_display_scan
    import life_pkg::scan_state_t, life_pkg::CAPTURE, life_pkg::SCAN,
           life_pkg::GRID_N, life_pkg::CELLS, life_pkg::flat_index;
#(
    parameter int DWELL = 1000,
    parameter int BLANK = 2
) (
    input  logic             clk,
    input  logic             _rst,
    input  logic [CELLS-1:0] grid_flat,
    input  logic             gen_tick,
    output logic [7:0]       row_sel,
    output logic [7:0]       col_data,
    output logic             frame_done,
    output logic [6:0]       live_count,
    output logic             extinct,
    output logic             still
);

    if (DWELL < 2 || DWELL > 65535 || BLANK < 1 || BLANK > 255) begin : g_param_chk
        $error("life_display_scan: DWELL or BLANK out of range");
    end

    localparam logic [15:0] DWELL_LAST = 16'(DWELL - 1);

    scan_state_t      state, state_nx;
    logic [2:0]       row, row_nx;
    logic [15:0]      dwell_cnt, dwell_nx;
    logic [CELLS-1:0] frame_buf;
    logic             pending;
    logic             load_q;    // a loading capture happened last cycle
    logic             same_q;    // that capture matched the buffer it replaced
    logic [6:0]       pop_cnt;
    logic             dwell_last;

`ifdef LIFE_SCAN_BLANK_EN
    localparam logic [7:0] BLANK_LAST = 8'(BLANK - 1);
    logic [7:0] blank_cnt, blank_nx;
`endif

    assign dwell_last = (dwell_cnt == DWELL_LAST);

    always_comb begin
        state_nx = state;
        row_nx   = row;
        dwell_nx = dwell_cnt;
`ifdef LIFE_SCAN_BLANK_EN
        blank_nx = blank_cnt;
`endif
        case (state)
            CAPTURE: begin
                state_nx = SCAN;
                row_nx   = 3'd0;
                dwell_nx = 16'd0;
            end
            SCAN: begin
                if (dwell_last) begin
                    dwell_nx = 16'd0;
                    if (row == 3'd7) begin
                        state_nx = CAPTURE;
                    end else begin
`ifdef LIFE_SCAN_BLANK_EN
                        state_nx = life_pkg::BLANK;
                        blank_nx = 8'd0;
`else
                        row_nx   = row + 3'd1;
`endif
                    end
                end else begin
                    dwell_nx = dwell_cnt + 16'd1;
                end
            end
`ifdef LIFE_SCAN_BLANK_EN
            life_pkg::BLANK: begin
                // Row index advances only when the gap ends.
                if (blank_cnt == BLANK_LAST) begin
                    state_nx = SCAN;
                    row_nx   = row + 3'd1;
                end else begin
                    blank_nx = blank_cnt + 8'd1;
                end
            end
`endif
            default: state_nx = CAPTURE;
        endcase
    end

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            state     <= CAPTURE;
            row       <= 3'd0;
            dwell_cnt <= 16'd0;
`ifdef LIFE_SCAN_BLANK_EN
            blank_cnt <= 8'd0;
`endif
        end else begin
            state     <= state_nx;
            row       <= row_nx;
            dwell_cnt <= dwell_nx;
`ifdef LIFE_SCAN_BLANK_EN
            blank_cnt <= blank_nx;
`endif
        end
    end

    // Single registered assignment per cycle keeps row_sel one-hot or zero at all times.
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            row_sel    <= 8'd0;
            col_data   <= 8'd0;
            frame_done <= 1'b0;
        end else begin
            if (state == SCAN) begin
                row_sel  <= 8'd1 << row;
                col_data <= frame_buf[flat_index(32'(row), 0) +: GRID_N];
            end else begin
                row_sel  <= 8'd0;
                col_data <= 8'd0;
            end
            frame_done <= (state == SCAN) && dwell_last && (row == 3'd7);
        end
    end

    // A gen_tick landing on the loading capture re-arms pending so that generation shows next frame.
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            frame_buf <= '0;
            pending   <= 1'b1;
            load_q    <= 1'b0;
            same_q    <= 1'b0;
        end else begin
            if (state == CAPTURE && pending) begin
                frame_buf <= grid_flat;
                same_q    <= (grid_flat == frame_buf);
                load_q    <= 1'b1;
                pending   <= gen_tick;
            end else begin
                load_q <= 1'b0;
                if (gen_tick) begin
                    pending <= 1'b1;
                end
            end
        end
    end

    life_popcount64 u_popcount (
        .vec   (frame_buf),
        .count (pop_cnt)
    );

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            live_count <= 7'd0;
            extinct    <= 1'b1;
            still      <= 1'b0;
        end else if (load_q) begin
            live_count <= pop_cnt;
            extinct    <= (frame_buf == '0);
            still      <= same_q;
        end
    end

endmodule
